ad9226_udp_packer: RTL and testbench
====================================

# ad9226_udp_packer

Packs the 12-bit AD9226 sample stream into 48-bit words and feeds the W5500 SPI/UDP interface block through its `data_input`, `data_input_valid` and `flush_requested` inputs. Four samples go into each 6-byte word. Words are buffered in a small FIFO so that samples keep arriving while SPI transfers are in progress. After a fixed number of words the block issues a flush, which makes the interface send the accumulated TX buffer as one UDP datagram.

## Interface
- `FIFO_DEPTH`, default 16: word FIFO depth; power of two, ≥ 2.
- `WORDS_PER_PACKET`, default 200: words per datagram (200 × 6 = 1200 bytes); range 1..65535.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `stream_enable`  in  1  high = accept samples; falling edge closes the current packet.
- `sample_valid`  in  1  `sample` is valid this cycle.
- `sample`  in  12  ADC code.
- `wiz_available`  in  1  the interface's `is_available` output.
- `data_input`  out  48  packed word to the interface.
- `data_input_valid`  out  1  one-cycle word push.
- `flush_requested`  out  1  one-cycle packet-send request.
- `overflow_count`  out  16  words dropped due to a full FIFO; saturates at 16'hFFFF.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Packer**
  - `lane` is a 2-bit counter. A sample with `sample_valid && stream_enable` is written at `lane`:
    - lane 0 → [47:36]
    - lane 1 → [35:24]
    - lane 2 → [23:12]
    - lane 3 → [11:0]
  - The first sample is the MSBs, so it goes out first on SPI.
  - When the sample at lane 3 is written, the completed word is registered and pushed to the FIFO on the next cycle. `lane` wraps to 0.
  - If the FIFO is full at the push and no pop happens in the same cycle, the word is dropped and `overflow_count` increments. Packing continues without a stall.
  - A simultaneous push and pop with a full FIFO is legal. The pop happens first, so the push is accepted.
  - `stream_enable` low: `lane` is cleared and any partial word is discarded.
- **Output FSM.** States IDLE, GAP, FLUSH_GAP, CLOSE.
  - IDLE, data push: when `wiz_available`=1, the FIFO is not empty and `word_count < WORDS_PER_PACKET`:
    - drive `data_input` = FIFO head and `data_input_valid`=1 for one cycle
    - pop the FIFO, increment `word_count`, go to GAP
  - IDLE, flush: when `wiz_available`=1 and `word_count == WORDS_PER_PACKET`:
    - pulse `flush_requested` for one cycle
    - clear `word_count`, go to FLUSH_GAP
  - The flush takes priority over a data push.
  - GAP and FLUSH_GAP last exactly one cycle, then return to IDLE. They cover the interface's registered `is_busy` rising. No output pulse is issued in these states.
  - A falling edge of `stream_enable` with `word_count > 0` or a non-empty FIFO sets `close_pending`. The FSM goes to CLOSE once the FIFO is empty and `wiz_available`=1:
    - pulse `flush_requested` (a short datagram)
    - clear `word_count` and `close_pending`
    - go to FLUSH_GAP
  - A falling edge with `word_count`=0 and an empty FIFO: no flush.
- `data_input` holds its last value when `data_input_valid`=0. Its value only matters during the pulse.
- `data_input_valid` and `flush_requested` are never high in the same cycle.

## Timing
- **Reset values:**
  - `data_input` = 0, `data_input_valid` = 0, `flush_requested` = 0
  - `overflow_count` = 0, `fifo_level` = 0
  - `lane` = 0, `word_count` = 0, `close_pending` = 0
  - FSM state = IDLE
- `rst` mid-transfer drops all buffered data immediately. A partial datagram already written into the W5500 stays there; this is the system's responsibility.
- **Latency:** lane-3 sample at cycle t → FIFO write at t+1 → `data_input_valid` at t+2 at the earliest, if `wiz_available` was high at t+2.
- All outputs are registered. `wiz_available` is only sampled in IDLE.
- **Maximum issue rate:** one pulse every 2 cycles; in practice it is limited by the SPI push time (about 146 clk per word).
- `fifo_level` updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- `word_count` width is 16 bits. The comparison is equality with `WORDS_PER_PACKET`.

## Test plan
- Reset, then 8 samples 0x001..0x008 with `wiz_available`=1 → two pushes:
  - 48'h001002003004
  - 48'h005006007008
  - pulses ≥ 2 cycles apart, no flush.
- `WORDS_PER_PACKET`=3, 12 samples, `wiz_available` held high → three `data_input_valid` pulses, then exactly one `flush_requested` pulse, `word_count` back to 0.
- `wiz_available`=0 with continuous `sample_valid`, `FIFO_DEPTH`=4:
  - `fifo_level` reaches 4
  - the 5th and 6th completed words are dropped → `overflow_count`=2
  - raising `wiz_available` → the first 4 words come out in order.
- Full FIFO with a pop in the same cycle as a push → no overflow increment; `fifo_level` stays 4.
- 6 samples, then `stream_enable` drops → the partial lane word is discarded, 1 word is pushed, then one `flush_requested`.
- Assert `rst` while the FIFO holds 3 words → all outputs are zero the next cycle, and no pulses follow until new samples arrive.

Source files
------------

// File: rtl/ad9226_udp_packer.sv
// Packs 12-bit AD9226 samples four to a 48-bit word and feeds them to
// the W5500 UDP interface, issuing a flush every WORDS_PER_PACKET words.
module ad9226_udp_packer #(
    parameter int FIFO_DEPTH       = 16,
    parameter int WORDS_PER_PACKET = 200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stream_enable,
    input  logic                          sample_valid,
    input  logic [11:0]                   sample,
    input  logic                          wiz_available,
    output logic [47:0]                   data_input,
    output logic                          data_input_valid,
    output logic                          flush_requested,
    output logic [15:0]                   overflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] WPP  = 16'(WORDS_PER_PACKET);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        FLUSH_GAP,
        CLOSE
    } state_t;

    logic [1:0]    lane;
    logic [35:0]   partial;
    logic [47:0]   push_word;
    logic          push_valid;
    logic          stream_en_d;

    logic [47:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [15:0]   word_count;
    logic          close_pending;
    state_t        state;

    logic          empty;
    logic          full;
    logic          pop;
    logic          accept;
    logic          fall;
    logic          has_data;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL);
        pop      = (state == IDLE) && wiz_available && !empty &&
                   (word_count < WPP);
        accept   = push_valid && (!full || pop);
        fall     = stream_en_d && !stream_enable;
        has_data = (word_count != 16'd0) || !empty || push_valid;
    end

    assign fifo_level = count;

    // Sample packer: first sample lands in the MSBs so it leaves SPI first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane        <= 2'd0;
            partial     <= '0;
            push_word   <= '0;
            push_valid  <= 1'b0;
            stream_en_d <= 1'b0;
        end else begin
            stream_en_d <= stream_enable;
            push_valid  <= 1'b0;
            if (!stream_enable) begin
                lane <= 2'd0;
            end else if (sample_valid) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: partial[35:24] <= sample;
                    2'd1: partial[23:12] <= sample;
                    2'd2: partial[11:0]  <= sample;
                    2'd3: begin
                        push_word  <= {partial, sample};
                        push_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pop is evaluated before push, so a full FIFO still takes a word
    // in the cycle it is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            overflow_count <= 16'd0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            if (push_valid && !accept && overflow_count != 16'hFFFF) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            data_input       <= '0;
            data_input_valid <= 1'b0;
            flush_requested  <= 1'b0;
            word_count       <= 16'd0;
            close_pending    <= 1'b0;
        end else begin
            data_input_valid <= 1'b0;
            flush_requested  <= 1'b0;
            if (fall && has_data) begin
                close_pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (wiz_available && word_count == WPP) begin
                        flush_requested <= 1'b1;
                        word_count      <= 16'd0;
                        state           <= FLUSH_GAP;
                    end else if (pop) begin
                        data_input       <= mem[rd_ptr];
                        data_input_valid <= 1'b1;
                        word_count       <= word_count + 16'd1;
                        state            <= GAP;
                    end else if (close_pending && empty && !push_valid) begin
                        // Nothing left to send: drop the close silently.
                        if (word_count == 16'd0) begin
                            close_pending <= 1'b0;
                        end else if (wiz_available) begin
                            state <= CLOSE;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                FLUSH_GAP: begin
                    state <= IDLE;
                end
                CLOSE: begin
                    flush_requested <= 1'b1;
                    word_count      <= 16'd0;
                    close_pending   <= 1'b0;
                    state           <= FLUSH_GAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9226_udp_packer.sv
// Bench for ad9226_udp_packer: queue-level model checked every cycle,
// plus directed scenarios with literal expected words.
module tb_ad9226_udp_packer;

    localparam int DEPTH = 4;
    localparam int WPP   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stream_enable = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd0;
    logic        wiz_available = 1'b0;
    logic [47:0] data_input;
    logic        data_input_valid;
    logic        flush_requested;
    logic [15:0] overflow_count;
    logic [2:0]  fifo_level;

    ad9226_udp_packer #(
        .FIFO_DEPTH       (DEPTH),
        .WORDS_PER_PACKET (WPP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stream_enable    (stream_enable),
        .sample_valid     (sample_valid),
        .sample           (sample),
        .wiz_available    (wiz_available),
        .data_input       (data_input),
        .data_input_valid (data_input_valid),
        .flush_requested  (flush_requested),
        .overflow_count   (overflow_count),
        .fifo_level       (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model state: FIFO contents as a plain queue, sample grouping by count.
    logic [47:0] mq[$];
    logic [47:0] log_q[$];
    int          n_flush = 0;
    logic [11:0] m_buf[4];
    int          m_n = 0;
    logic        m_pend = 1'b0;
    logic [47:0] m_pw = '0;
    int          m_wc = 0;
    logic        m_close = 1'b0;
    logic [15:0] m_ovf = 16'd0;
    logic [47:0] m_last = '0;
    logic        m_en_prev = 1'b0;
    int          cyc = 0;
    int          last_pulse = -10;

    always @(posedge clk) begin
        logic        i_rst;
        logic        i_en;
        logic        i_v;
        logic [11:0] i_s;
        i_rst = rst;
        i_en  = stream_enable;
        i_v   = sample_valid;
        i_s   = sample;
        #1;
        cyc++;
        if (i_rst) begin
            mq.delete();
            m_n = 0; m_pend = 1'b0; m_wc = 0; m_close = 1'b0;
            m_ovf = 16'd0; m_last = '0; m_en_prev = 1'b0;
            last_pulse = -10;
            chk("rst_data", data_input, 48'd0);
            chk("rst_valid", 48'(data_input_valid), 48'd0);
            chk("rst_flush", 48'(flush_requested), 48'd0);
            chk("rst_ovf", 48'(overflow_count), 48'd0);
            chk("rst_level", 48'(fifo_level), 48'd0);
        end else begin
            if (m_en_prev && !i_en && (m_wc > 0 || mq.size() > 0 || m_pend))
                m_close = 1'b1;
            chk("exclusive", 48'(data_input_valid && flush_requested), 48'd0);
            if (data_input_valid || flush_requested) begin
                chk("spacing", 48'(cyc - last_pulse >= 2), 48'd1);
                last_pulse = cyc;
            end
            if (data_input_valid) begin
                chk("pop_nonempty", 48'(mq.size() > 0), 48'd1);
                chk("pop_allowed", 48'(m_wc < WPP), 48'd1);
                if (mq.size() > 0) begin
                    chk("word", data_input, mq[0]);
                    void'(mq.pop_front());
                end
                m_wc++;
                m_last = data_input;
                log_q.push_back(data_input);
            end
            if (flush_requested) begin
                n_flush++;
                if (m_wc == WPP) begin
                    m_wc = 0;
                end else begin
                    chk("close_flush_ok",
                        48'(m_close && m_wc > 0 && mq.size() == 0), 48'd1);
                    m_wc = 0;
                    m_close = 1'b0;
                end
            end
            chk("data_hold", data_input, m_last);
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(m_pw);
                else if (m_ovf != 16'hFFFF) m_ovf++;
                m_pend = 1'b0;
            end
            if (!i_en) begin
                m_n = 0;
            end else if (i_v) begin
                m_buf[m_n] = i_s;
                m_n++;
                if (m_n == 4) begin
                    m_pw = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                    m_pend = 1'b1;
                    m_n = 0;
                end
            end
            m_en_prev = i_en;
            chk("level", 48'(fifo_level), 48'(mq.size()));
            chk("ovf", 48'(overflow_count), 48'(m_ovf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        stream_enable = 1'b1;
        cycles(2);
        rst = 1'b0;
        log_q.delete();
        n_flush = 0;
    endtask

    task automatic send(input logic [11:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample = base + 12'(i);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Basic packing, two words, no flush.
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_reset_valid", 48'(data_input_valid), 48'd0);
        chk("t1_reset_level", 48'(fifo_level), 48'd0);
        wiz_available = 1'b1;
        send(12'h001, 8);
        cycles(10);
        chk("t1_count", 48'(log_q.size()), 48'd2);
        chk("t1_w0", log_q[0], 48'h001002003004);
        chk("t1_w1", log_q[1], 48'h005006007008);
        chk("t1_noflush", 48'(n_flush), 48'd0);

        // Full packet: three words then one flush.
        do_reset();
        wiz_available = 1'b1;
        send(12'h100, 12);
        cycles(12);
        chk("t2_count", 48'(log_q.size()), 48'd3);
        chk("t2_w2", log_q[2], 48'h10810910a10b);
        chk("t2_flush", 48'(n_flush), 48'd1);

        // Overflow while the interface is busy.
        do_reset();
        wiz_available = 1'b0;
        send(12'h200, 24);
        cycles(3);
        chk("t3_level", 48'(fifo_level), 48'd4);
        chk("t3_ovf", 48'(overflow_count), 48'd2);
        wiz_available = 1'b1;
        cycles(20);
        chk("t3_count", 48'(log_q.size()), 48'd4);
        chk("t3_w0", log_q[0], 48'h200201202203);
        chk("t3_w3", log_q[3], 48'h20c20d20e20f);
        chk("t3_flush", 48'(n_flush), 48'd1);

        // Push and pop on the same edge with a full FIFO.
        do_reset();
        wiz_available = 1'b0;
        send(12'h300, 16);
        cycles(3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample = 12'h310 + 12'(i);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        wiz_available = 1'b1;
        @(negedge clk);
        wiz_available = 1'b0;
        chk("t4_level", 48'(fifo_level), 48'd4);
        chk("t4_ovf", 48'(overflow_count), 48'd0);
        wiz_available = 1'b1;
        cycles(20);
        chk("t4_count", 48'(log_q.size()), 48'd5);
        chk("t4_w0", log_q[0], 48'h300301302303);
        chk("t4_w4", log_q[4], 48'h310311312313);

        // Stream close: partial word dropped, short datagram flushed.
        do_reset();
        wiz_available = 1'b1;
        send(12'h400, 6);
        stream_enable = 1'b0;
        cycles(10);
        chk("t5_count", 48'(log_q.size()), 48'd1);
        chk("t5_w0", log_q[0], 48'h400401402403);
        chk("t5_flush", 48'(n_flush), 48'd1);
        stream_enable = 1'b1;
        send(12'h500, 4);
        cycles(8);
        chk("t5_w1", log_q[1], 48'h500501502503);
        chk("t5_flush2", 48'(n_flush), 48'd1);

        // Reset with buffered words.
        do_reset();
        wiz_available = 1'b0;
        send(12'h600, 12);
        cycles(3);
        chk("t6_level", 48'(fifo_level), 48'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_data", data_input, 48'd0);
        chk("t6_valid", 48'(data_input_valid), 48'd0);
        chk("t6_flushq", 48'(flush_requested), 48'd0);
        chk("t6_level0", 48'(fifo_level), 48'd0);
        chk("t6_ovf", 48'(overflow_count), 48'd0);
        rst = 1'b0;
        wiz_available = 1'b1;
        log_q.delete();
        n_flush = 0;
        cycles(12);
        chk("t6_nopush", 48'(log_q.size()), 48'd0);
        chk("t6_noflush", 48'(n_flush), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
